// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty-cycle ramp controller.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ramp_state_t;

    localparam logic [7:0] MAX_DUTY = 8'd100;

    // Saturate a requested duty to the legal 0..100 range.
    function automatic logic [7:0] clamp_duty(input logic [7:0] d);
        return (d > MAX_DUTY) ? MAX_DUTY : d;
    endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// Free-running PWM period counter; tick is high during the last cycle of each period.
module pwm_period_tick #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned PWM_FREQ = 1_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end

    // tick is registered from the next count so it lines up with cnt == PERIOD-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= (PERIOD == 1);
        end else begin
            cnt  <= cnt_next;
            tick <= (cnt_next == LAST);
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer: ramps the PWM duty toward a requested target in 1 % steps
// aligned to PWM period boundaries, with instant-apply and emergency-stop paths.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned PWM_FREQ     = 1_000,
    parameter int unsigned STEP_PERIODS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_target,
    input  logic       req_instant,
    input  logic       stop,
    output logic [7:0] duty_cycle,
    output logic       busy,
    output logic       done
);

    localparam int unsigned STEP_W = $clog2(STEP_PERIODS + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);

    ramp_state_t       state;
    logic [7:0]        tgt;
    logic [STEP_W-1:0] step_cnt;
    logic              tick;
    logic [7:0]        req_tgt_c;
    logic [7:0]        duty_step_c;

    pwm_period_tick #(
        .CLK_FREQ (CLK_FREQ),
        .PWM_FREQ (PWM_FREQ)
    ) u_period_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign req_ready = (state == IDLE) && !stop;
    assign req_tgt_c = clamp_duty(req_target);

    // Next duty for a step, saturated so duty never leaves 0..100.
    always_comb begin
        duty_step_c = duty_cycle;
        if (state == UP && duty_cycle < MAX_DUTY) begin
            duty_step_c = duty_cycle + 8'd1;
        end else if (state == DOWN && duty_cycle != 8'd0) begin
            duty_step_c = duty_cycle - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tgt        <= 8'd0;
            step_cnt   <= '0;
            duty_cycle <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                // Emergency stop overrides requests and any coincident step.
                state      <= IDLE;
                step_cnt   <= '0;
                duty_cycle <= 8'd0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid) begin
                            tgt      <= req_tgt_c;
                            step_cnt <= '0;
                            if (req_instant) begin
                                duty_cycle <= req_tgt_c;
                                done       <= 1'b1;
                            end else if (req_tgt_c == duty_cycle) begin
                                done <= 1'b1;
                            end else if (req_tgt_c > duty_cycle) begin
                                state <= UP;
                                busy  <= 1'b1;
                            end else begin
                                state <= DOWN;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    UP, DOWN: begin
                        if (tick) begin
                            if (step_cnt == STEP_LAST) begin
                                step_cnt   <= '0;
                                duty_cycle <= duty_step_c;
                                if (duty_step_c == tgt) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                step_cnt <= step_cnt + STEP_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with PERIOD=10 and STEP_PERIODS=2 (20 cycles per 1 % step).
module tb_pwm_ramp_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_target;
    logic       req_instant;
    logic       stop;
    logic [7:0] duty_cycle;
    logic       busy;
    logic       done;

    int checks;
    int errors;
    int phase;

    pwm_ramp_ctrl #(
        .CLK_FREQ     (1000),
        .PWM_FREQ     (100),
        .STEP_PERIODS (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_target  (req_target),
        .req_instant (req_instant),
        .stop        (stop),
        .duty_cycle  (duty_cycle),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent model of the PWM period phase (tick edge follows phase == 9).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase <= 0;
        else        phase <= (phase == 9) ? 0 : phase + 1;
    end

    // Leave the bench just before a tick edge so the next accept is phase-aligned.
    task automatic align_to_tick();
        for (int i = 0; i < 20 && phase != 9; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (phase != 9) begin
            errors++;
            $display("FAIL align_to_tick: phase %0d required 9", phase);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_target = 8'd0; req_instant = 1'b0; stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (duty_cycle !== 8'd0) begin errors++; $display("FAIL reset_duty: got %0d required 0", duty_cycle); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ramp_up();
        int exp_duty;
        align_to_tick();
        req_target = 8'd5; req_instant = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            exp_duty = c / 20;
            checks++; if (duty_cycle !== 8'(exp_duty)) begin errors++; $display("FAIL up_duty c=%0d: got %0d required %0d", c, duty_cycle, exp_duty); end
            checks++; if (done !== (c == 100)) begin errors++; $display("FAIL up_done c=%0d: got %b required %b", c, done, (c == 100)); end
            checks++; if (busy !== (c < 100)) begin errors++; $display("FAIL up_busy c=%0d: got %b required %b", c, busy, (c < 100)); end
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL up_done_width: got %b required 0", done); end
    endtask

    task automatic test_ramp_down();
        int exp_duty;
        align_to_tick();
        req_target = 8'd2; req_instant = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            exp_duty = 5 - c / 20;
            checks++; if (duty_cycle !== 8'(exp_duty)) begin errors++; $display("FAIL down_duty c=%0d: got %0d required %0d", c, duty_cycle, exp_duty); end
            checks++; if (done !== (c == 60)) begin errors++; $display("FAIL down_done c=%0d: got %b required %b", c, done, (c == 60)); end
            checks++; if (busy !== (c < 60)) begin errors++; $display("FAIL down_busy c=%0d: got %b required %b", c, busy, (c < 60)); end
        end
    endtask

    task automatic test_instant_clamp();
        req_target = 8'd200; req_instant = 1'b1; req_valid = 1'b1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL instant_ready: got %b required 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0; req_instant = 1'b0;
        checks++; if (duty_cycle !== 8'd100) begin errors++; $display("FAIL instant_duty: got %0d required 100", duty_cycle); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL instant_done: got %b required 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL instant_busy: got %b required 0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL instant_done_width: got %b required 0", done); end
    endtask

    task automatic test_equal_target();
        req_target = 8'd100; req_instant = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL equal_done: got %b required 1", done); end
        checks++; if (duty_cycle !== 8'd100) begin errors++; $display("FAIL equal_duty: got %0d required 100", duty_cycle); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL equal_busy: got %b required 0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL equal_done_width: got %b required 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL equal_idle: got %b required 0", busy); end
    endtask

    task automatic test_stop();
        int seen_done;
        req_target = 8'd0; req_instant = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_instant = 1'b0;
        checks++; if (duty_cycle !== 8'd0) begin errors++; $display("FAIL stop_prep_duty: got %0d required 0", duty_cycle); end
        align_to_tick();
        req_target = 8'd50; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen_done = 0;
        for (int c = 1; c <= 140; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done++;
        end
        checks++; if (duty_cycle !== 8'd7) begin errors++; $display("FAIL stop_pre_duty: got %0d required 7", duty_cycle); end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL stop_early_done: got %0d pulses required 0", seen_done); end
        stop = 1'b1; req_valid = 1'b1; req_target = 8'd30;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stop_ready: got %b required 0", req_ready); end
        @(posedge clk); #1;
        checks++; if (duty_cycle !== 8'd0) begin errors++; $display("FAIL stop_duty: got %0d required 0", duty_cycle); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done: got %b required 0", done); end
        stop = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_no_accept: got %b required 0", busy); end
        checks++; if (duty_cycle !== 8'd0) begin errors++; $display("FAIL stop_hold_duty: got %0d required 0", duty_cycle); end
    endtask

    task automatic test_back_to_back();
        align_to_tick();
        req_target = 8'd2; req_instant = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_target = 8'd30;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 5 || c == 39) begin
                checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy c=%0d: got %b required 0", c, req_ready); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy c=%0d: got %b required 1", c, busy); end
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b required 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_fall: got %b required 0", busy); end
        checks++; if (duty_cycle !== 8'd2) begin errors++; $display("FAIL b2b_duty: got %0d required 2", duty_cycle); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle: got %b required 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b required 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_width: got %b required 0", done); end
        repeat (25) @(posedge clk);
        #1;
        checks++; if (duty_cycle !== 8'd3) begin errors++; $display("FAIL b2b_ramp_duty: got %0d required 3", duty_cycle); end
        rst_n = 1'b0;
        #1;
        checks++; if (duty_cycle !== 8'd0) begin errors++; $display("FAIL midreset_duty: got %0d required 0", duty_cycle); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b required 0", done); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b required 1", req_ready); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_target = 8'd42; req_instant = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_instant = 1'b0;
        checks++; if (duty_cycle !== 8'd42) begin errors++; $display("FAIL post_reset_duty: got %0d required 42", duty_cycle); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL post_reset_done: got %b required 1", done); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_instant_clamp();
        test_equal_target();
        test_stop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
